cpc_ram_mapper_gen2: RTL



---
 rtl/cpc_ram_mapper_gen2.sv | 128 ++++++++++++
 1 files changed

// File: rtl/cpc_ram_mapper_gen2.sv
// cpc_ram_mapper_gen2: DK'Tronics-compatible RAM bank mapper with Z80 memory-cycle tracking,
// optional 464 A15/RD* overdrive requests and optional config readback.
module cpc_ram_mapper_gen2 #(
    parameter int PORT_BITS = 0,
    parameter int OVERDRIVE = 0,
    parameter int READBACK  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iorq_b,
    input  logic                 mreq_b,
    input  logic                 rfsh_b,
    input  logic                 m1_b,
    input  logic                 wr_b,
    input  logic                 rd_b,
    input  logic                 ramrd_b,
    input  logic [7:0]           adr_hi,
    input  logic                 adr14,
    input  logic [7:0]           data,
    output logic [PORT_BITS+4:0] ramadr,
    output logic                 ramcs_b,
    output logic                 ramoe_b,
    output logic                 ramwe_b,
    output logic                 ramdis,
    output logic                 a15_ovd,
    output logic                 rd_ovd,
    output logic [7:0]           dout,
    output logic                 dout_oe
);
    localparam logic [7:0] NPORTS = 8'(1 << PORT_BITS);
    localparam logic [1:0] PB     = 2'(PORT_BITS);
    localparam int         SW     = (PORT_BITS > 0) ? PORT_BITS : 1;

    typedef enum logic [1:0] {IDLE, MRD, MWR, TAIL} state_t;
    state_t state, state_nx;

    logic       cardsel_q, mode3_q, a15_lat, hit_lat;
    logic [2:0] bank_q, block_q;
    logic [7:0] off;
    logic       in_range, wr_dec, mwr_start, a15, raw_hit, hit;
    logic [1:0] raw_blk, blk;

    assign off       = 8'h7F - adr_hi;
    assign in_range  = !adr_hi[7] && (off < NPORTS);
    assign wr_dec    = !iorq_b && !wr_b && !adr_hi[7] && (data[7:6] == 2'b11);
    assign mwr_start = (state == IDLE) && !mreq_b && rfsh_b && rd_b && m1_b;
    // In IDLE the live A15 is used so an overdriven A15 maps within the same clock.
    assign a15       = (state == IDLE) ? adr_hi[7] : a15_lat;

    always_comb begin
        raw_hit = 1'b0;
        raw_blk = 2'b11;
        if (block_q[2]) begin
            raw_hit = !adr_hi[7] && adr14;
            raw_blk = block_q[1:0];
        end else if (block_q[1:0] == 2'b01) begin
            raw_hit = adr_hi[7] && adr14;
        end else if (block_q[1:0] == 2'b10) begin
            raw_hit = 1'b1;
            raw_blk = {adr_hi[7], adr14};
        end else if (block_q[1:0] == 2'b11) begin
            raw_hit = a15 && adr14;
        end
    end

    assign hit = cardsel_q && raw_hit;
    assign blk = hit ? raw_blk : 2'b00;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!mreq_b && rfsh_b) state_nx = (rd_b && m1_b) ? MWR : MRD;
            MRD:     if (mreq_b) state_nx = IDLE;
            MWR:     if (mreq_b) state_nx = TAIL;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            a15_lat <= 1'b0;
            hit_lat <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE) begin
                a15_lat <= adr_hi[7];
                hit_lat <= hit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cardsel_q <= 1'b0;
            mode3_q   <= 1'b0;
            bank_q    <= 3'b000;
            block_q   <= 3'b000;
        end else if (wr_dec) begin
            cardsel_q <= in_range;
            if (in_range) begin
                {bank_q, block_q} <= data[5:0];
                mode3_q           <= (data[2:0] == 3'b011);
            end
        end
    end

    if (PORT_BITS > 0) begin : g_slice
        logic [SW-1:0] slice_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) slice_q <= '0;
            else if (wr_dec && in_range) slice_q <= off[SW-1:0];
        end
        assign ramadr = {slice_q, bank_q, blk};
    end else begin : g_noslice
        assign ramadr = {bank_q, blk};
    end

    assign ramcs_b = !hit || mreq_b || !rfsh_b;
    assign ramoe_b = ramrd_b;
    assign ramwe_b = wr_b;
    assign ramdis  = hit && cardsel_q;
    assign a15_ovd = (OVERDRIVE != 0) && cardsel_q && mode3_q && adr14 && rfsh_b && !mreq_b;
    assign rd_ovd  = (OVERDRIVE != 0) &&
                     ((mwr_start && hit) || ((state == MWR || state == TAIL) && hit_lat));
    assign dout_oe = (READBACK != 0) && !iorq_b && !rd_b && in_range;
    assign dout    = dout_oe ? {PB, bank_q, block_q} : 8'h00;
endmodule
